// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
//   - if_state_e   : fetch FSM states
//   - ifid_entry_t : instruction word plus its pc+increment, as held in IF/ID or the skid slot
//   - opcode field bounds, default reset PC / increment, NOP word
package if_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned     DEFAULT_PC_INC   = 4;
  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } ifid_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched instruction and its pc+increment.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load_i              capture instr_i/pc_plus4_i, mark full
//   unload_i            entry consumed, mark empty
//   clear_i             entry discarded, mark empty
//   instr_i, pc_plus4_i entry payload in
//   full_o              slot holds a valid entry
//   instr_o, pc_plus4_o entry payload out
module if_skid_buf
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic            full_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic        full_q, full_d;
  ifid_entry_t entry_q, entry_d;

  // Next-state: emptying wins over a simultaneous load.
  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (load_i) begin
      full_d  = 1'b1;
      entry_d = '{instr: instr_i, pc_plus4: pc_plus4_i};
    end
    if (unload_i || clear_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full_o     = full_q;
  assign instr_o    = entry_q.instr;
  assign pc_plus4_o = entry_q.pc_plus4;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem port, one-entry skid
// slot and the IF/ID pipeline register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req/imem_addr              fetch request and byte address (current PC)
//   imem_gnt/imem_rvalid/imem_rdata memory handshake and returned instruction
//   branch_taken/branch_target      redirect from EX/MEM (target forced word aligned)
//   stall                           ID cannot accept; IF/ID held
//   ifid_valid/instr/pc_plus4       IF/ID register contents
//   ifid_opcode                     ifid_instr[31:26] for the control decoder
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_INC   = DEFAULT_PC_INC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic [5:0]  ifid_opcode
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pp4_q, ifid_pp4_d;

  logic            skid_load, skid_unload, skid_clear, skid_full;
  logic [XLEN-1:0] skid_instr, skid_pp4;

  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target;
  logic            slot_free;

  assign pc_next   = pc_q + XLEN'(PC_INC);
  assign target    = branch_target & ~32'h0000_0003;
  assign slot_free = !ifid_valid_q || !stall;

  if_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (skid_load),
    .unload_i   (skid_unload),
    .clear_i    (skid_clear),
    .instr_i    (imem_rdata),
    .pc_plus4_i (pc_next),
    .full_o     (skid_full),
    .instr_o    (skid_instr),
    .pc_plus4_o (skid_pp4)
  );

  // Next-state and IF/ID update; a redirect overrides everything at the end.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q & stall;  // consumed by ID unless stalled
    ifid_instr_d = ifid_instr_q;
    ifid_pp4_d   = ifid_pp4_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;

    unique case (state_q)
      S_REQ: begin
        // req_q gates gnt: the first cycle after reset has no live request.
        if (req_q && imem_gnt) begin
          state_d = branch_taken ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid && !branch_taken) begin
          pc_d = pc_next;
          if (slot_free) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pp4_d   = pc_next;
            state_d      = S_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (imem_rvalid) begin
          state_d = S_REQ;
        end else if (branch_taken) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          skid_clear = 1'b1;
          state_d    = S_REQ;
        end else if (!stall && skid_full) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = skid_instr;
          ifid_pp4_d   = skid_pp4;
          skid_unload  = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_DROP: begin
        // The stale response must drain before a new request may issue.
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (branch_taken) begin
      pc_d         = target;
      ifid_valid_d = 1'b0;
    end
  end

  assign req_d = (state_d == S_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_WORD;
      ifid_pp4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pp4_q   <= ifid_pp4_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pp4_q;
  assign ifid_opcode   = ifid_instr_q[OPCODE_MSB:OPCODE_LSB];

endmodule
